hdmi_video_port: RTL and testbench

Parametrised, registered video output stage between the CGA/MDA pixel pipeline and the HDMI transmitter. Converts 4-bit IRGB pixels to COLOR_BITS-per-channel RGB, either through the fixed CGA colour map (with brown correction) or through a programmable 16-entry palette. The palette is double-buffered so updates land glitch-free at the start of vertical sync. Sync, display-enable and colour outputs stay cycle-aligned through a configurable pipeline.

---
 rtl/hdmi_video_port.sv | 135 +++++++++++++
 tb/tb_hdmi_video_port.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_video_port.sv
// Registered video output stage: converts IRGB pixels to RGB through the fixed CGA map or a
// double-buffered 16-entry palette, with syncs and display enable kept cycle-aligned.
module hdmi_video_port #(
  parameter int COLOR_BITS  = 8,
  parameter int EXTRA_DELAY = 0
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [3:0]              i_video,
  input  logic                    i_display_enable,
  input  logic                    i_hsync,
  input  logic                    i_vsync,
  input  logic                    i_hs_invert,
  input  logic                    i_vs_invert,
  input  logic                    i_mode_palette,
  input  logic                    i_pal_we,
  input  logic [3:0]              i_pal_addr,
  input  logic [3*COLOR_BITS-1:0] i_pal_data,
  input  logic                    i_pal_commit,
  output logic                    o_pal_pending,
  output logic [COLOR_BITS-1:0]   o_hdmi_red,
  output logic [COLOR_BITS-1:0]   o_hdmi_grn,
  output logic [COLOR_BITS-1:0]   o_hdmi_blu,
  output logic                    o_hdmi_hs,
  output logic                    o_hdmi_vs,
  output logic                    o_hdmi_de,
  output logic                    o_hdmi_clk
);

  localparam int CW = 3 * COLOR_BITS;
  localparam int PW = CW + 3;

  function automatic logic [COLOR_BITS-1:0] expandLevel(input logic [1:0] lvl);
    logic [COLOR_BITS-1:0] v;
    v = '0;
    for (int b = 0; b < COLOR_BITS; b++) begin
      v[COLOR_BITS-1-b] = (b % 2 == 0) ? lvl[1] : lvl[0];
    end
    return v;
  endfunction

  // Index 6 would be dark yellow; real CGA monitors pull green down to make brown.
  function automatic logic [CW-1:0] cgaColor(input logic [3:0] idx);
    logic [1:0] lr, lg, lb;
    lr = {idx[2], idx[3]};
    lg = {idx[1], idx[3]};
    lb = {idx[0], idx[3]};
    if (idx == 4'd6) lg = 2'b01;
    return {expandLevel(lr), expandLevel(lg), expandLevel(lb)};
  endfunction

  logic [3:0]    r_s1_video;
  logic          r_s1_de, r_s1_hs, r_s1_vs, r_s1_mode;
  logic          r_s1_vsraw, r_s1_vsraw_prev;
  logic          r_pending;
  logic [CW-1:0] r_shadow [16];
  logic [CW-1:0] r_active [16];
  logic [PW-1:0] r_s2;
  logic [PW-1:0] w_out;
  logic [CW-1:0] w_color;
  logic          w_vs_rise, w_copy;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1_video      <= '0;
      r_s1_de         <= 1'b0;
      r_s1_hs         <= 1'b0;
      r_s1_vs         <= 1'b0;
      r_s1_mode       <= 1'b0;
      r_s1_vsraw      <= 1'b0;
      r_s1_vsraw_prev <= 1'b0;
    end else begin
      r_s1_video      <= i_video;
      r_s1_de         <= i_display_enable;
      r_s1_hs         <= i_hsync ^ i_hs_invert;
      r_s1_vs         <= i_vsync ^ i_vs_invert;
      r_s1_mode       <= i_mode_palette;
      r_s1_vsraw      <= i_vsync;
      r_s1_vsraw_prev <= r_s1_vsraw;
    end
  end

  assign w_vs_rise = r_s1_vsraw & ~r_s1_vsraw_prev;
  assign w_copy    = w_vs_rise & (r_pending | i_pal_commit);

  // The bulk copy reads the shadow before this edge's write, so a same-cycle write waits for the next commit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 16; i++) begin
        r_shadow[i] <= cgaColor(4'(i));
        r_active[i] <= cgaColor(4'(i));
      end
      r_pending <= 1'b0;
    end else begin
      if (w_copy) r_active <= r_shadow;
      if (i_pal_we) r_shadow[i_pal_addr] <= i_pal_data;
      if (w_copy) r_pending <= 1'b0;
      else if (i_pal_commit) r_pending <= 1'b1;
    end
  end

  assign w_color = r_s1_mode ? r_active[r_s1_video] : cgaColor(r_s1_video);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_s2 <= '0;
    else            r_s2 <= {(r_s1_de ? w_color : {CW{1'b0}}), r_s1_hs, r_s1_vs, r_s1_de};
  end

  generate
    if (EXTRA_DELAY > 0) begin : g_delay
      logic [PW-1:0] r_dly [EXTRA_DELAY];
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          for (int i = 0; i < EXTRA_DELAY; i++) r_dly[i] <= '0;
        end else begin
          r_dly[0] <= r_s2;
          for (int i = 1; i < EXTRA_DELAY; i++) r_dly[i] <= r_dly[i-1];
        end
      end
      assign w_out = r_dly[EXTRA_DELAY-1];
    end else begin : g_nodelay
      assign w_out = r_s2;
    end
  endgenerate

  assign o_hdmi_red    = w_out[PW-1 -: COLOR_BITS];
  assign o_hdmi_grn    = w_out[PW-1-COLOR_BITS -: COLOR_BITS];
  assign o_hdmi_blu    = w_out[PW-1-2*COLOR_BITS -: COLOR_BITS];
  assign o_hdmi_hs     = w_out[2];
  assign o_hdmi_vs     = w_out[1];
  assign o_hdmi_de     = w_out[0];
  assign o_pal_pending = r_pending;
  assign o_hdmi_clk    = i_clk;

endmodule

// File: tb/tb_hdmi_video_port.sv
// Directed bench for hdmi_video_port: an 8-bit/no-delay instance and a 5-bit/two-extra-stage
// instance driven from the same pixel stream.
module tb_hdmi_video_port;

  logic        clk = 1'b0;
  logic        resetN;
  logic [3:0]  video;
  logic        de, hsync, vsync, hsInv, vsInv, modePal, palWe, palCommit;
  logic [3:0]  palAddr;
  logic [23:0] palData;
  logic [14:0] palData5;

  logic        pend8, hs8, vs8, de8, hdmiClk8;
  logic [7:0]  red8, grn8, blu8;
  logic        pend5, hs5, vs5, de5, hdmiClk5;
  logic [4:0]  red5, grn5, blu5;

  int total = 0;
  int bad   = 0;

  logic [23:0] cgaTable [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

  always #5 clk = ~clk;

  hdmi_video_port #(.COLOR_BITS(8), .EXTRA_DELAY(0)) dut8 (
    .i_clk(clk), .i_reset_n(resetN), .i_video(video), .i_display_enable(de),
    .i_hsync(hsync), .i_vsync(vsync), .i_hs_invert(hsInv), .i_vs_invert(vsInv),
    .i_mode_palette(modePal), .i_pal_we(palWe), .i_pal_addr(palAddr),
    .i_pal_data(palData), .i_pal_commit(palCommit), .o_pal_pending(pend8),
    .o_hdmi_red(red8), .o_hdmi_grn(grn8), .o_hdmi_blu(blu8),
    .o_hdmi_hs(hs8), .o_hdmi_vs(vs8), .o_hdmi_de(de8), .o_hdmi_clk(hdmiClk8)
  );

  hdmi_video_port #(.COLOR_BITS(5), .EXTRA_DELAY(2)) dut5 (
    .i_clk(clk), .i_reset_n(resetN), .i_video(video), .i_display_enable(de),
    .i_hsync(hsync), .i_vsync(vsync), .i_hs_invert(hsInv), .i_vs_invert(vsInv),
    .i_mode_palette(modePal), .i_pal_we(palWe), .i_pal_addr(palAddr),
    .i_pal_data(palData5), .i_pal_commit(palCommit), .o_pal_pending(pend5),
    .o_hdmi_red(red5), .o_hdmi_grn(grn5), .o_hdmi_blu(blu5),
    .o_hdmi_hs(hs5), .o_hdmi_vs(vs5), .o_hdmi_de(de5), .o_hdmi_clk(hdmiClk5)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic d, input logic h, input logic vs);
    video = v;
    de    = d;
    hsync = h;
    vsync = vs;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    resetN = 1'b0; hsInv = 0; vsInv = 0; modePal = 0;
    palWe = 0; palAddr = 0; palData = 0; palData5 = 0; palCommit = 0;
    applyStimulus(4'd0, 0, 0, 0);
    tick(2);
    checkOutput("reset_rgb", {8'h0, red8, grn8, blu8}, 32'h0);
    checkOutput("reset_hs", hs8, 0);
    checkOutput("reset_vs", vs8, 0);
    checkOutput("reset_de", de8, 0);
    checkOutput("reset_pending", pend8, 0);
    checkOutput("hdmi_clk", hdmiClk8, clk);
    resetN = 1'b1;
    tick();

    // fixed-map sweep: after driving pixel k and one edge, the output shows pixel k-1
    for (int k = 0; k <= 16; k++) begin
      applyStimulus((k < 16) ? 4'(k) : 4'd0, (k < 16), 0, 0);
      tick();
      if (k >= 1) begin
        checkOutput($sformatf("sweep_rgb_%0d", k - 1), {8'h0, red8, grn8, blu8}, {8'h0, cgaTable[k-1]});
        checkOutput($sformatf("sweep_de_%0d", k - 1), de8, 1);
      end
    end

    // 5-bit, two extra stages: total latency 4
    applyStimulus(4'd0, 0, 0, 0);
    tick(4);
    checkOutput("d5_idle_de", de5, 0);
    applyStimulus(4'd7, 1, 1, 1);
    tick(3);
    checkOutput("d5_early_de", de5, 0);
    checkOutput("d5_early_hs", hs5, 0);
    checkOutput("d5_early_rgb", {17'h0, red5, grn5, blu5}, 32'h0);
    tick();
    checkOutput("d5_rgb", {17'h0, red5, grn5, blu5}, 32'h56B5);
    checkOutput("d5_hs", hs5, 1);
    checkOutput("d5_vs", vs5, 1);
    checkOutput("d5_de", de5, 1);

    // palette: shadow write + commit mid-frame stays pending until vsync rise
    modePal = 1;
    applyStimulus(4'd3, 1, 0, 0);
    tick(3);
    checkOutput("pal_initial", {8'h0, red8, grn8, blu8}, 32'h00AAAA);
    palWe = 1; palAddr = 4'd3; palData = 24'h123456;
    tick();
    palWe = 0; palCommit = 1;
    tick();
    palCommit = 0;
    checkOutput("pal_pending_rise", pend8, 1);
    tick(3);
    checkOutput("pal_before_vs", {8'h0, red8, grn8, blu8}, 32'h00AAAA);
    checkOutput("pal_pending_hold", pend8, 1);
    applyStimulus(4'd3, 1, 0, 1);
    tick();
    checkOutput("pal_pending_stage1", pend8, 1);
    tick();
    checkOutput("pal_pending_clear", pend8, 0);
    checkOutput("pal_inflight_old", {8'h0, red8, grn8, blu8}, 32'h00AAAA);
    tick();
    checkOutput("pal_new", {8'h0, red8, grn8, blu8}, 32'h123456);

    // write and commit in the vsync-rise cycle: copy takes pre-write shadow
    applyStimulus(4'd3, 1, 0, 0);
    tick(2);
    applyStimulus(4'd3, 1, 0, 1);
    tick();
    palWe = 1; palAddr = 4'd3; palData = 24'hABCDEF; palCommit = 1;
    tick();
    palWe = 0; palCommit = 0;
    checkOutput("same_pending", pend8, 0);
    tick(2);
    checkOutput("same_old_shadow", {8'h0, red8, grn8, blu8}, 32'h123456);
    applyStimulus(4'd3, 1, 0, 0);
    tick(2);
    palCommit = 1;
    tick();
    palCommit = 0;
    checkOutput("second_pending", pend8, 1);
    applyStimulus(4'd3, 1, 0, 1);
    tick(3);
    checkOutput("second_rgb", {8'h0, red8, grn8, blu8}, 32'hABCDEF);
    checkOutput("second_pending_clear", pend8, 0);

    // blanking and sync inversion
    hsInv = 1; vsInv = 1;
    applyStimulus(4'd15, 0, 0, 0);
    tick(2);
    checkOutput("blank_rgb", {8'h0, red8, grn8, blu8}, 32'h0);
    checkOutput("blank_hs", hs8, 1);
    checkOutput("blank_vs", vs8, 1);
    checkOutput("blank_de", de8, 0);
    hsInv = 0; vsInv = 0;

    // asynchronous reset mid-line with a commit pending and a modified palette
    palCommit = 1;
    tick();
    palCommit = 0;
    applyStimulus(4'd15, 1, 1, 0);
    tick(2);
    checkOutput("prereset_rgb", {8'h0, red8, grn8, blu8}, 32'hFFFFFF);
    checkOutput("prereset_pending", pend8, 1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("async_rgb", {8'h0, red8, grn8, blu8}, 32'h0);
    checkOutput("async_hs", hs8, 0);
    checkOutput("async_de", de8, 0);
    checkOutput("async_pending", pend8, 0);
    tick(2);
    resetN = 1'b1;
    modePal = 1;
    applyStimulus(4'd6, 1, 0, 0);
    tick(2);
    checkOutput("post_reset_brown", {8'h0, red8, grn8, blu8}, 32'hAA5500);
    checkOutput("post_reset_pending", pend8, 0);
    applyStimulus(4'd3, 1, 0, 0);
    tick(2);
    checkOutput("post_reset_reload", {8'h0, red8, grn8, blu8}, 32'h00AAAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
